// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / 32/32 divide unit.
// Operands are reduced to magnitudes at start. 32 radix-2 steps then run on
// one 64-bit accumulator: shift-add for multiply, restoring shift-subtract
// for divide. A final cycle applies the sign correction and loads Hi/Lo.
// A divide by zero skips the iteration and only raises div_zero.
module mult_div_unit (
    input  logic        Clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DZ   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [1:0]  op_r;
    logic [31:0] a_mag_r;
    logic [31:0] b_mag_r;
    logic [63:0] acc_r;
    logic [4:0]  cnt_r;
    logic        neg_q_r;      // product or quotient must be negated
    logic        neg_rem_r;    // remainder must be negated
    logic        busy_r;
    logic        done_r;
    logic        div_zero_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        is_div_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_rem_sh_s;
    logic [33:0] div_diff_s;
    logic [63:0] acc_step_s;
    logic [63:0] mul_res_s;
    logic [31:0] quo_res_s;
    logic [31:0] rem_res_s;

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign Hi       = hi_r;
    assign Lo       = lo_r;

    // Operand decode: signedness and magnitudes of the incoming A/B.
    always_comb begin
        is_div_s = op[1];
        a_neg_s  = (~op[0]) & A[31];
        b_neg_s  = (~op[0]) & B[31];
        if (a_neg_s) begin
            a_mag_s = 32'd0 - A;
        end else begin
            a_mag_s = A;
        end
        if (b_neg_s) begin
            b_mag_s = 32'd0 - B;
        end else begin
            b_mag_s = B;
        end
    end

    // One radix-2 iteration step of the accumulator for the latched operation.
    always_comb begin
        mul_sum_s    = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, a_mag_r} : 33'd0);
        div_rem_sh_s = acc_r[63:31];
        div_diff_s   = {1'b0, div_rem_sh_s} - {2'b00, b_mag_r};
        acc_step_s   = acc_r;
        if (op_r[1]) begin
            if (!div_diff_s[33]) begin
                acc_step_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
            end else begin
                acc_step_s = {div_rem_sh_s[31:0], acc_r[30:0], 1'b0};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[31:1]};
        end
    end

    // Sign correction of the finished magnitude results.
    always_comb begin
        if (neg_q_r) begin
            mul_res_s = 64'd0 - acc_r;
            quo_res_s = 32'd0 - acc_r[31:0];
        end else begin
            mul_res_s = acc_r;
            quo_res_s = acc_r[31:0];
        end
        if (neg_rem_r) begin
            rem_res_s = 32'd0 - acc_r[63:32];
        end else begin
            rem_res_s = acc_r[63:32];
        end
    end

    // Next-state decode of the control FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (is_div_s && (B == 32'd0)) begin
                        state_nxt_s = DZ;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 5'd31) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX:     state_nxt_s = IDLE;
            DZ:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register; busy is registered alongside so it tracks the state exactly.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Datapath: operand latch, iteration, result load and status flags.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            op_r       <= 2'b00;
            a_mag_r    <= 32'd0;
            b_mag_r    <= 32'd0;
            acc_r      <= 64'd0;
            cnt_r      <= 5'd0;
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r       <= op;
                        a_mag_r    <= a_mag_s;
                        b_mag_r    <= b_mag_s;
                        // Multiply iterates over the multiplier; divide over the dividend.
                        acc_r      <= {32'd0, (is_div_s ? a_mag_s : b_mag_s)};
                        cnt_r      <= 5'd0;
                        neg_q_r    <= a_neg_s ^ b_neg_s;
                        neg_rem_r  <= a_neg_s;
                        div_zero_r <= 1'b0;
                    end
                end
                CALC: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + 5'd1;
                end
                FIX: begin
                    if (op_r[1]) begin
                        hi_r <= rem_res_s;
                        lo_r <= quo_res_s;
                    end else begin
                        hi_r <= mul_res_s[63:32];
                        lo_r <= mul_res_s[31:0];
                    end
                    done_r <= 1'b1;
                end
                DZ: begin
                    done_r     <= 1'b1;
                    div_zero_r <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        Clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int checks   = 0;
    int failures = 0;
    int lat;
    int bcnt;
    int dcnt;

    mult_div_unit dut (
        .Clk      (Clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns at the first negedge after the start edge.
    // Operands are scrambled right after the start edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Count negedges from the current one (index 1) until done is seen, bounded.
    task automatic wait_done(output int l, output int bc);
        l  = 1;
        bc = 0;
        while (!done && l < 100) begin
            if (busy) bc++;
            @(negedge Clk);
            l++;
        end
        checks++;
        assert (!(busy && done)) else begin
            failures++;
            $error("FAIL busy_done_overlap observed=1 expected=0");
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        launch(o, a, b);
        wait_done(lat, bcnt);
        check({tag, "_latency"}, lat, 64'd34);
        check({tag, "_hi"}, Hi, exp_hi);
        check({tag, "_lo"}, Lo, exp_lo);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = 32'd0;
        B     = 32'd0;
        #12;
        check("rst_busy", busy, 64'd0);
        check("rst_done", done, 64'd0);
        check("rst_div_zero", div_zero, 64'd0);
        check("rst_hi", Hi, 64'd0);
        check("rst_lo", Lo, 64'd0);
        @(negedge Clk);
        reset = 1'b1;

        // MULTU max x max: 33 busy cycles, done on the 34th cycle
        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bcnt);
        check("multu_max_latency", lat, 64'd34);
        check("multu_max_busy_cycles", bcnt, 64'd33);
        check("multu_max_hi", Hi, 64'hFFFFFFFE);
        check("multu_max_lo", Lo, 64'h00000001);
        check("multu_max_dz", div_zero, 64'd0);
        @(negedge Clk);
        check("done_single_pulse", done, 64'd0);

        run("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run("mult_min_sq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run("mult_m1x1", 2'b00, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run("multu_2p32", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
        run("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_7dm2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run("div_m7dm2", 2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003);
        run("divu_max_d1", 2'b11, 32'hFFFFFFFF, 32'd1, 32'h00000000, 32'hFFFFFFFF);
        run("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

        // DIVU by zero: done right after the start edge, Hi/Lo keep 2/14
        launch(2'b11, 32'd100, 32'd0);
        wait_done(lat, bcnt);
        check("dz_latency", lat, 64'd2);
        check("dz_busy_cycles", bcnt, 64'd1);
        check("dz_flag", div_zero, 64'd1);
        check("dz_hi_hold", Hi, 64'd2);
        check("dz_lo_hold", Lo, 64'd14);
        @(negedge Clk);
        @(negedge Clk);
        check("dz_flag_held", div_zero, 64'd1);

        // DIV min / -1 with a stray start pulse mid-CALC
        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        check("dz_cleared_by_start", div_zero, 64'd0);
        check("calc_busy", busy, 64'd1);
        for (int i = 1; i < 10; i++) @(negedge Clk);
        op    = 2'b11;
        A     = 32'd5;
        B     = 32'd1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        check("div_wrap_latency", lat, 64'd24);
        check("div_wrap_hi", Hi, 64'h00000000);
        check("div_wrap_lo", Lo, 64'h80000000);
        check("div_wrap_dz", div_zero, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (done) dcnt++;
        end
        check("ignored_start_no_extra_done", dcnt, 64'd0);
        check("ignored_start_idle", busy, 64'd0);

        // start held high re-triggers right after done
        @(negedge Clk);
        op    = 2'b01;
        A     = 32'd6;
        B     = 32'd7;
        start = 1'b1;
        @(negedge Clk);
        wait_done(lat, bcnt);
        check("hold_first_latency", lat, 64'd34);
        check("hold_first_lo", Lo, 64'd42);
        @(negedge Clk);
        start = 1'b0;
        check("hold_retrigger_busy", busy, 64'd1);
        check("hold_retrigger_done_low", done, 64'd0);
        wait_done(lat, bcnt);
        check("hold_second_latency", lat, 64'd34);
        check("hold_second_lo", Lo, 64'd42);

        // Reset at CALC step 10 aborts; start ignored during reset
        launch(2'b00, 32'hFFFFFFFD, 32'd7);
        for (int i = 1; i < 10; i++) @(negedge Clk);
        check("pre_abort_busy", busy, 64'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 64'd0);
        check("abort_done", done, 64'd0);
        check("abort_hi", Hi, 64'd0);
        check("abort_lo", Lo, 64'd0);
        op    = 2'b01;
        A     = 32'd3;
        B     = 32'd3;
        start = 1'b1;
        dcnt  = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (done || busy) dcnt++;
        end
        start = 1'b0;
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        check("reset_ignores_start", dcnt, 64'd0);
        check("post_reset_idle", busy, 64'd0);
        run("post_reset_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Port: Clk  in  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: start  in  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 Port: A  in  32  multiplicand or dividend (rs value).
REQ-007 Port: B  in  32  multiplier or divisor (rt value).
REQ-008 Port: busy  out  1  high while an operation is in progress.
REQ-009 Port: done  out  1  one-cycle pulse when Hi/Lo update or div-by-zero completes.
REQ-010 Port: div_zero  out  1  held high from done until the next accepted start; flags DIV/DIVU with B=0.
REQ-011 Port: Hi  out  32  upper product half or remainder, registered.
REQ-012 Port: Lo  out  32  lower product half or quotient, registered.

Function
REQ-013 The block SHALL use the states IDLE, CALC, FIX and DZ.
REQ-014 IDLE with start=1 at edge N: latch op, |A|, |B| (magnitudes for signed ops, raw values for unsigned), latch result-sign flags, clear iteration counter to 0, and clear div_zero.
REQ-015 At that same edge N, the next state SHALL be DZ if op is DIV or DIVU and B==0; otherwise CALC.
REQ-016 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide, both on 64-bit internal accumulators.
REQ-017 CALC SHALL run exactly 32 steps (edges N+1..N+32), with the counter counting 0..31; at counter 31 the next state is FIX.
REQ-018 FIX (edge N+33) SHALL apply the sign correction and load Hi/Lo, pulse done for the following cycle, and return to IDLE.
REQ-019 DZ (edge N+1) SHALL pulse done, set div_zero=1, leave Hi/Lo unchanged, and return to IDLE.
REQ-020 busy SHALL be 1 in CALC, FIX and DZ, and 0 in IDLE; busy and done are never high in the same cycle.
REQ-021 MULT: Hi:Lo SHALL equal the 64-bit two's-complement product of signed A and signed B.
REQ-022 MULTU: Hi:Lo SHALL equal the 64-bit unsigned product.
REQ-023 DIV: Lo SHALL be the quotient truncated toward zero, with sign = sign(A) XOR sign(B); Hi SHALL be the remainder, with the sign of A.
REQ-024 DIVU: Lo SHALL be the unsigned quotient and Hi the unsigned remainder.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL yield Lo=0x80000000, Hi=0 (wrap), with no flag.
REQ-026 start while busy=1 SHALL be ignored; it is neither queued nor allowed to alter the latched operands.
REQ-027 A/B changes after the start edge SHALL NOT affect the result.
REQ-028 start held high SHALL re-trigger in the first IDLE cycle after done, i.e. one new operation per accepted edge.
REQ-029 Hi/Lo SHALL change only at FIX or on reset.

Reset
REQ-030 reset=0 SHALL immediately force: state IDLE; busy=0, done=0, div_zero=0; Hi=0, Lo=0; counter=0; internal accumulators cleared.
REQ-031 Reset during CALC/FIX/DZ SHALL abort the operation with no done pulse; the first start after reset release SHALL be serviced normally.
REQ-032 start SHALL be ignored while reset=0.

Verification
REQ-033 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> busy 33 cycles, done in cycle N+34, Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-034 MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
REQ-035 DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU A=100, B=7 -> Lo=14, Hi=2.
REQ-036 DIVU A=100, B=0 after a prior result -> done one cycle after start, div_zero=1, Hi/Lo hold previous values; next start clears div_zero.
REQ-037 DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0; second start pulsed mid-CALC -> ignored, single done.
REQ-038 Assert reset at CALC step 10 -> busy=0, Hi=Lo=0, no done; release, then MULTU 6x7 -> Lo=42, Hi=0.
